// File: rtl/uv_vga_pkg.sv
// Shared timing defaults, region boundaries and pixel types for the VGA output path.
package uv_vga_pkg;

    // Default 640x480@60 timing
    localparam int unsigned H_ACTIVE_DEF   = 640;
    localparam int unsigned H_FP_DEF       = 16;
    localparam int unsigned H_SYNC_DEF     = 96;
    localparam int unsigned H_BP_DEF       = 48;
    localparam int unsigned V_ACTIVE_DEF   = 480;
    localparam int unsigned V_FP_DEF       = 10;
    localparam int unsigned V_SYNC_DEF     = 2;
    localparam int unsigned V_BP_DEF       = 33;
    localparam int unsigned UV_LATENCY_DEF = 2;

    localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Inclusive sync windows for the default timing
    localparam int unsigned H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
    localparam int unsigned V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic [3:0] hue;
        logic [3:0] luma;
    } uv_t;

    // Sync fields are active-high here; inversion happens at the pins
    typedef struct packed {
        logic hblank;
        logic vblank;
        logic hsync;
        logic vsync;
    } raster_flags_t;

    localparam raster_flags_t FLAGS_IDLE = '{hblank: 1'b1, vblank: 1'b1, hsync: 1'b0, vsync: 1'b0};

    function automatic int unsigned raster_total(input int unsigned active, input int unsigned fp,
                                                 input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/uv_palette_rom.sv
// UV byte to RGB444 palette: hue 0 is grayscale, hues 1..15 scale a per-hue base colour by luma.
module uv_palette_rom
    import uv_vga_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] addr,
    output rgb444_t    data
);

    // Brightest shade of each NTSC 7800 hue
    function automatic logic [11:0] hue_base(input logic [3:0] hue);
        logic [11:0] base;
        case (hue)
            4'd1:    base = 12'hC80;
            4'd2:    base = 12'hE60;
            4'd3:    base = 12'hE44;
            4'd4:    base = 12'hE48;
            4'd5:    base = 12'hC4C;
            4'd6:    base = 12'h84E;
            4'd7:    base = 12'h44E;
            4'd8:    base = 12'h48E;
            4'd9:    base = 12'h4AE;
            4'd10:   base = 12'h4CC;
            4'd11:   base = 12'h4C8;
            4'd12:   base = 12'h4C4;
            4'd13:   base = 12'h8C4;
            4'd14:   base = 12'hAC4;
            4'd15:   base = 12'hCA4;
            default: base = 12'h000;
        endcase
        return base;
    endfunction

    // channel * (luma + 1) / 16, so luma 15 yields the base colour itself
    function automatic logic [3:0] shade(input logic [3:0] chan, input logic [3:0] luma);
        logic [8:0] prod;
        prod = 9'(chan) * (9'(luma) + 9'd1);
        return prod[7:4];
    endfunction

    function automatic rgb444_t lookup(input uv_t uv);
        rgb444_t     px;
        logic [11:0] base;
        base = hue_base(uv.hue);
        if (uv.hue == 4'd0) begin
            px = '{r: uv.luma, g: uv.luma, b: uv.luma};
        end else begin
            px = '{r: shade(base[11:8], uv.luma), g: shade(base[7:4], uv.luma),
                   b: shade(base[3:0], uv.luma)};
        end
        return px;
    endfunction

    // Registered read, advancing only on enable
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else if (en) begin
            data <= lookup(uv_t'(addr));
        end
    end

endmodule

// File: rtl/uv_vga_out.sv
// VGA raster generator and UV-to-RGB output stage, sync/blank aligned to the pixel pipeline.
module uv_vga_out #(
    parameter int unsigned H_ACTIVE   = uv_vga_pkg::H_ACTIVE_DEF,
    parameter int unsigned H_FP       = uv_vga_pkg::H_FP_DEF,
    parameter int unsigned H_SYNC     = uv_vga_pkg::H_SYNC_DEF,
    parameter int unsigned H_BP       = uv_vga_pkg::H_BP_DEF,
    parameter int unsigned V_ACTIVE   = uv_vga_pkg::V_ACTIVE_DEF,
    parameter int unsigned V_FP       = uv_vga_pkg::V_FP_DEF,
    parameter int unsigned V_SYNC     = uv_vga_pkg::V_SYNC_DEF,
    parameter int unsigned V_BP       = uv_vga_pkg::V_BP_DEF,
    parameter int unsigned UV_LATENCY = uv_vga_pkg::UV_LATENCY_DEF
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic [7:0] uv_in,
    output logic [9:0] vga_row,
    output logic [9:0] vga_col,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       hsync,
    output logic       vsync,
    output logic       hblank,
    output logic       vblank,
    output logic       frame_start
);

    import uv_vga_pkg::*;

    localparam int unsigned HTotal   = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned VTotal   = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HSyncBeg = H_ACTIVE + H_FP;
    localparam int unsigned HSyncEnd = HSyncBeg + H_SYNC - 1;
    localparam int unsigned VSyncBeg = V_ACTIVE + V_FP;
    localparam int unsigned VSyncEnd = VSyncBeg + V_SYNC - 1;
    // Raw flags wait out the UV return latency plus the palette register
    localparam int unsigned Dly      = UV_LATENCY + 1;

    logic [9:0]    col_q, col_d, row_q, row_d;
    logic          col_last, row_last;
    logic          frame_start_q;
    raster_flags_t raw_flags, out_flags;
    raster_flags_t dly_q [Dly];
    rgb444_t       pal_q;

    // Next raster position
    always_comb begin
        col_last = (col_q == 10'(HTotal - 1));
        row_last = (row_q == 10'(VTotal - 1));
        col_d    = col_last ? 10'd0 : col_q + 10'd1;
        row_d    = row_q;
        if (col_last) begin
            row_d = row_last ? 10'd0 : row_q + 10'd1;
        end
    end

    // Raster counters and the one-sysclk wrap pulse
    always_ff @(posedge sysclk) begin
        if (reset) begin
            col_q         <= '0;
            row_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= pix_ce && col_last && row_last;
            if (pix_ce) begin
                col_q <= col_d;
                row_q <= row_d;
            end
        end
    end

    // Timing decode of the current counter position
    always_comb begin
        raw_flags        = FLAGS_IDLE;
        raw_flags.hblank = (col_q >= 10'(H_ACTIVE));
        raw_flags.vblank = (row_q >= 10'(V_ACTIVE));
        raw_flags.hsync  = (col_q >= 10'(HSyncBeg)) && (col_q <= 10'(HSyncEnd));
        raw_flags.vsync  = (row_q >= 10'(VSyncBeg)) && (row_q <= 10'(VSyncEnd));
    end

    // Sync/blank delay line, flushed to idle on reset
    always_ff @(posedge sysclk) begin
        if (reset) begin
            for (int i = 0; i < int'(Dly); i++) begin
                dly_q[i] <= FLAGS_IDLE;
            end
        end else if (pix_ce) begin
            dly_q[0] <= raw_flags;
            for (int i = 1; i < int'(Dly); i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    uv_palette_rom u_palette (
        .clk   (sysclk),
        .reset (reset),
        .en    (pix_ce),
        .addr  (uv_in),
        .data  (pal_q)
    );

    // Outputs: both sides of the colour mask are registered, so no glitches reach the pins
    always_comb begin
        out_flags = dly_q[Dly-1];
        hblank    = out_flags.hblank;
        vblank    = out_flags.vblank;
        hsync     = ~out_flags.hsync;
        vsync     = ~out_flags.vsync;
        red       = pal_q.r;
        green     = pal_q.g;
        blue      = pal_q.b;
        if (out_flags.hblank || out_flags.vblank) begin
            red   = 4'd0;
            green = 4'd0;
            blue  = 4'd0;
        end
    end

    assign vga_col     = col_q;
    assign vga_row     = row_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_uv_vga_out.sv
// Bench: full-size and shrunken-timing instances checked every cycle against a tick-count model.
module tb_uv_vga_out;

    logic       sysclk;
    logic       reset;
    logic       pix_ce;
    logic [7:0] uv_in;

    logic [9:0] b_row, b_col, s_row, s_col;
    logic [3:0] b_r, b_g, b_b, s_r, s_g, s_b;
    logic       b_hs, b_vs, b_hbl, b_vbl, b_fs;
    logic       s_hs, s_vs, s_hbl, s_vbl, s_fs;

    int checks = 0;
    int errors = 0;

    // Model state: pix_ce edges since reset, last sampled uv, whether the last edge was a tick
    int         n       = 0;
    logic [7:0] last_uv = 8'h00;
    bit         edge_q  = 1'b0;
    bit         model_ok = 1'b0;

    localparam logic [11:0] HUE_TAB [16] = '{
        12'h000, 12'hC80, 12'hE60, 12'hE44, 12'hE48, 12'hC4C, 12'h84E, 12'h44E,
        12'h48E, 12'h4AE, 12'h4CC, 12'h4C8, 12'h4C4, 12'h8C4, 12'hAC4, 12'hCA4
    };

    uv_vga_out u_big (
        .sysclk      (sysclk),
        .reset       (reset),
        .pix_ce      (pix_ce),
        .uv_in       (uv_in),
        .vga_row     (b_row),
        .vga_col     (b_col),
        .red         (b_r),
        .green       (b_g),
        .blue        (b_b),
        .hsync       (b_hs),
        .vsync       (b_vs),
        .hblank      (b_hbl),
        .vblank      (b_vbl),
        .frame_start (b_fs)
    );

    uv_vga_out #(
        .H_ACTIVE   (16),
        .H_FP       (2),
        .H_SYNC     (3),
        .H_BP       (3),
        .V_ACTIVE   (6),
        .V_FP       (1),
        .V_SYNC     (2),
        .V_BP       (1),
        .UV_LATENCY (2)
    ) u_small (
        .sysclk      (sysclk),
        .reset       (reset),
        .pix_ce      (pix_ce),
        .uv_in       (uv_in),
        .vga_row     (s_row),
        .vga_col     (s_col),
        .red         (s_r),
        .green       (s_g),
        .blue        (s_b),
        .hsync       (s_hs),
        .vsync       (s_vs),
        .hblank      (s_hbl),
        .vblank      (s_vbl),
        .frame_start (s_fs)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40) begin
                $display("FAIL %s: got %0d, want %0d (tick %0d, t=%0t)", name, act, exp, n, $time);
            end
        end
    endtask

    function automatic logic [11:0] pal_ref(input logic [7:0] uv);
        int hue, luma;
        logic [11:0] base;
        hue  = int'(uv[7:4]);
        luma = int'(uv[3:0]);
        if (hue == 0) return {uv[3:0], uv[3:0], uv[3:0]};
        base = HUE_TAB[hue];
        return {4'((int'(base[11:8]) * (luma + 1)) / 16),
                4'((int'(base[7:4]) * (luma + 1)) / 16),
                4'((int'(base[3:0]) * (luma + 1)) / 16)};
    endfunction

    // Outputs after n ticks show the raster position of tick n-3 and the uv sampled at tick n
    task automatic check_inst(input string tag, input int ha, input int hf, input int hsw,
                              input int hbp, input int va, input int vf, input int vsw,
                              input int vbp, input logic [9:0] row, input logic [9:0] col,
                              input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                              input logic hsn, input logic vsn, input logic hbl,
                              input logic vbl, input logic fs);
        int ht, vt, p, c, rr;
        bit eh, ev, ehs, evs, efs;
        logic [11:0] rgb;
        ht = ha + hf + hsw + hbp;
        vt = va + vf + vsw + vbp;
        cmp({tag, ".col"}, int'(col), n % ht);
        cmp({tag, ".row"}, int'(row), (n / ht) % vt);
        if (n < 3) begin
            eh = 1'b1; ev = 1'b1; ehs = 1'b0; evs = 1'b0;
        end else begin
            p   = n - 3;
            c   = p % ht;
            rr  = (p / ht) % vt;
            eh  = (c >= ha);
            ev  = (rr >= va);
            ehs = (c >= ha + hf) && (c < ha + hf + hsw);
            evs = (rr >= va + vf) && (rr < va + vf + vsw);
        end
        rgb = (eh || ev) ? 12'h000 : pal_ref(last_uv);
        efs = edge_q && (n > 0) && (n % (ht * vt) == 0);
        cmp({tag, ".hblank"}, int'(hbl), int'(eh));
        cmp({tag, ".vblank"}, int'(vbl), int'(ev));
        cmp({tag, ".hsync"}, int'(hsn), int'(!ehs));
        cmp({tag, ".vsync"}, int'(vsn), int'(!evs));
        cmp({tag, ".rgb"}, int'({r, g, b}), int'(rgb));
        cmp({tag, ".frame_start"}, int'(fs), int'(efs));
    endtask

    always @(posedge sysclk) begin
        if (reset) begin
            n        <= 0;
            edge_q   <= 1'b0;
            model_ok <= 1'b1;
        end else if (pix_ce) begin
            n       <= n + 1;
            last_uv <= uv_in;
            edge_q  <= 1'b1;
        end else begin
            edge_q  <= 1'b0;
        end
    end

    always @(negedge sysclk) begin
        if (model_ok) begin
            check_inst("big", 640, 16, 96, 48, 480, 10, 2, 33, b_row, b_col, b_r, b_g, b_b,
                       b_hs, b_vs, b_hbl, b_vbl, b_fs);
            check_inst("small", 16, 2, 3, 3, 6, 1, 2, 1, s_row, s_col, s_r, s_g, s_b,
                       s_hs, s_vs, s_hbl, s_vbl, s_fs);
        end
    end

    task automatic step(input bit pce, input logic [7:0] uv, input bit rst);
        reset  = rst;
        pix_ce = pce;
        uv_in  = uv;
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        int first_low, low_cnt, fs_cnt, vbl_cnt, px_cnt;
        logic [7:0] uv;
        reset  = 1'b1;
        pix_ce = 1'b0;
        uv_in  = 8'h00;

        // Reset state, then one full line on the full-size raster
        step(1'b0, 8'h00, 1'b1);
        cmp("rst.col", int'(b_col), 0);
        cmp("rst.row", int'(b_row), 0);
        cmp("rst.hsync", int'(b_hs), 1);
        cmp("rst.vsync", int'(b_vs), 1);
        cmp("rst.hblank", int'(b_hbl), 1);
        cmp("rst.vblank", int'(b_vbl), 1);
        cmp("rst.rgb", int'({b_r, b_g, b_b}), 0);
        cmp("rst.frame_start", int'(b_fs), 0);
        first_low = -1;
        low_cnt   = 0;
        for (int i = 1; i <= 810; i++) begin
            step(1'b1, 8'h00, 1'b0);
            if (i == 799) begin
                cmp("line.col799", int'(b_col), 799);
                cmp("line.row_before_wrap", int'(b_row), 0);
            end
            if (i == 800) begin
                cmp("line.col_wrap", int'(b_col), 0);
                cmp("line.row_after_wrap", int'(b_row), 1);
            end
            if (b_hs == 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = i;
            end
        end
        cmp("line.hsync_first_low", first_low, 659);
        cmp("line.hsync_low_ticks", low_cnt, 96);

        // Colour lookup on directed uv values
        step(1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            case (i)
                9:       uv = 8'h18;
                10:      uv = 8'h0F;
                11:      uv = 8'h00;
                12:      uv = 8'hFF;
                default: uv = 8'h55;
            endcase
            step(1'b1, uv, 1'b0);
            if (i == 9)  cmp("colour.hue1_luma8", int'({b_r, b_g, b_b}), 'h640);
            if (i == 10) begin
                cmp("colour.white", int'({b_r, b_g, b_b}), 'hFFF);
                cmp("colour.white_hblank", int'(b_hbl), 0);
            end
            if (i == 11) cmp("colour.black", int'({b_r, b_g, b_b}), 'h000);
            if (i == 12) cmp("colour.hue15_luma15", int'({b_r, b_g, b_b}), 'hCA4);
        end

        // Constant 0xFF over a full small frame: frame pulse, vsync, vblank, visible pixels
        step(1'b0, 8'h00, 1'b1);
        first_low = -1;
        low_cnt   = 0;
        fs_cnt    = 0;
        vbl_cnt   = 0;
        px_cnt    = 0;
        for (int i = 1; i <= 260; i++) begin
            step(1'b1, 8'hFF, 1'b0);
            if (s_fs) fs_cnt++;
            if (s_vs == 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = i;
            end
            if (i >= 4 && i <= 243) begin
                if (s_vbl) vbl_cnt++;
                if ({s_r, s_g, s_b} != 12'h000) px_cnt++;
            end
        end
        cmp("frame.frame_start_pulses", fs_cnt, 1);
        cmp("frame.vsync_first_low", first_low, 171);
        cmp("frame.vsync_low_ticks", low_cnt, 48);
        cmp("frame.vblank_ticks", vbl_cnt, 96);
        cmp("frame.lit_pixels", px_cnt, 96);

        // Reset mid-frame with pix_ce low
        step(1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 130; i++) step(1'b1, 8'h3C, 1'b0);
        cmp("midrst.pre_row", int'(s_row), 5);
        cmp("midrst.pre_col", int'(s_col), 10);
        step(1'b0, 8'h3C, 1'b1);
        cmp("midrst.row", int'(s_row), 0);
        cmp("midrst.col", int'(s_col), 0);
        cmp("midrst.big_col", int'(b_col), 0);
        cmp("midrst.hsync", int'(s_hs), 1);
        cmp("midrst.hblank", int'(s_hbl), 1);
        cmp("midrst.rgb", int'({b_r, b_g, b_b}), 0);
        step(1'b0, 8'h3C, 1'b0);
        step(1'b0, 8'h3C, 1'b0);

        // Irregular pix_ce at about 30% duty with random uv
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(0, 99) < 30), 8'($urandom_range(0, 255)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
